// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: sequential binary-to-BCD converter (shift-and-add-3).
// One input bit per clock, MSB first, with a start/done handshake,
// optional two's-complement input and overflow detection/saturation.

// Per-digit correction: a digit of 5 or more gets 3 added before the shift,
// so that the doubling carries correctly into the next decimal digit.
module bin2bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    // Add-3 correction for a single BCD digit
    always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_conv #(
    parameter int BIN_W    = 16,
    parameter int DIGITS   = 5,
    parameter int SATURATE = 1
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  signed_en,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  overflow
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    localparam logic [5:0]          LAST_SHIFT = 6'(BIN_W - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES  = {DIGITS{4'h9}};

    state_t                   state, state_nxt;
    logic                     load, shift_en, finish;

    logic [BIN_W-1:0]         shreg;
    logic [DIGITS-1:0][3:0]   digits, digits_adj, digits_nxt;
    logic                     carry_out;
    logic [5:0]               shift_cnt;
    logic                     sign_q, ovf_q;

    logic                     neg_in;
    logic [BIN_W-1:0]         magnitude;

    // Negative inputs are converted by magnitude; the most negative value
    // wraps to 2^(BIN_W-1), which still fits as a BIN_W-bit unsigned.
    assign neg_in    = signed_en & bin_in[BIN_W-1];
    assign magnitude = neg_in ? (~bin_in) + BIN_W'(1) : bin_in;

    // One correction unit per digit
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bin2bcd_digit_adj u_adj (
            .d (digits[i]),
            .q (digits_adj[i])
        );
    end

    // Shift corrected digits left by one, pulling in the next binary bit;
    // the bit leaving the top digit marks a result beyond DIGITS digits.
    assign {carry_out, digits_nxt} = {digits_adj, shreg[BIN_W-1]};

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge sys_clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (shift_cnt == LAST_SHIFT) state_nxt = FINISH;
            end
            FINISH: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered results; results move only on finish or reset
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            shreg     <= '0;
            digits    <= '0;
            shift_cnt <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            sign_out  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                shreg     <= magnitude;
                digits    <= '0;
                sign_q    <= neg_in;
                ovf_q     <= 1'b0;
                shift_cnt <= '0;
            end
            if (shift_en) begin
                digits    <= digits_nxt;
                shreg     <= shreg << 1;
                ovf_q     <= ovf_q | carry_out;
                shift_cnt <= shift_cnt + 6'd1;
            end
            if (finish) begin
                bcd_out  <= (ovf_q && (SATURATE != 0)) ? ALL_NINES : digits;
                sign_out <= sign_q;
                overflow <= ovf_q;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_conv.sv
// Bench for bin2bcd_conv: three instances (5 digits saturating, 4 digits
// saturating, 4 digits truncating) share one stimulus stream and are checked
// every cycle against an arithmetic model, plus literal spot checks.
module tb_bin2bcd_conv;
    localparam int BIN_W = 16;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_en = 1'b0;
    logic [15:0] bin_in = '0;
    logic [2:0]  busy_v, done_v, sign_v, ovf_v;
    logic [19:0] bcd0;
    logic [15:0] bcd1, bcd2;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    bin2bcd_conv #(.BIN_W(16), .DIGITS(5), .SATURATE(1)) u0 (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .signed_en(signed_en),
        .bin_in(bin_in), .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd0),
        .sign_out(sign_v[0]), .overflow(ovf_v[0]));
    bin2bcd_conv #(.BIN_W(16), .DIGITS(4), .SATURATE(1)) u1 (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .signed_en(signed_en),
        .bin_in(bin_in), .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd1),
        .sign_out(sign_v[1]), .overflow(ovf_v[1]));
    bin2bcd_conv #(.BIN_W(16), .DIGITS(4), .SATURATE(0)) u2 (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .signed_en(signed_en),
        .bin_in(bin_in), .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd2),
        .sign_out(sign_v[2]), .overflow(ovf_v[2]));

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Decimal conversion by plain division; bit 40 is the overflow flag.
    function automatic logic [40:0] to_bcd(input longint v, input int d, input bit sat);
        longint lim = 1;
        longint x = v;
        logic [40:0] r = '0;
        for (int i = 0; i < d; i++) lim = lim * 10;
        r[40] = (v >= lim);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = (r[40] && sat) ? 4'd9 : 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    int          DIG[3] = '{5, 4, 4};
    bit          SAT[3] = '{1, 1, 0};
    bit          m_busy = 0, m_done = 0, m_neg = 0, m_sign = 0;
    int          m_rem = 0;
    longint      m_mag = 0;
    logic [40:0] m_res[3] = '{default: '0};

    // Model: accepted start -> busy for BIN_W+1 edges, then done with the result
    always @(posedge sys_clk) begin
        if (!reset_n) begin
            m_busy <= 0; m_done <= 0; m_rem <= 0; m_sign <= 0;
            for (int k = 0; k < 3; k++) m_res[k] <= '0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                    m_sign <= m_neg;
                    for (int k = 0; k < 3; k++) m_res[k] <= to_bcd(m_mag, DIG[k], SAT[k]);
                end
            end else if (start) begin
                m_busy <= 1;
                m_rem  <= BIN_W + 1;
                m_neg  <= signed_en && bin_in[15];
                m_mag  <= (signed_en && bin_in[15]) ? 65536 - longint'(bin_in) : longint'(bin_in);
            end
        end
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge sys_clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("busy%0d", k), busy_v[k], m_busy);
                chk($sformatf("done%0d", k), done_v[k], m_done);
                chk($sformatf("sign%0d", k), sign_v[k], m_sign);
                chk($sformatf("ovf%0d", k), ovf_v[k], m_res[k][40]);
            end
            chk("bcd0", bcd0, m_res[0][19:0]);
            chk("bcd1", bcd1, m_res[1][15:0]);
            chk("bcd2", bcd2, m_res[2][15:0]);
        end
    end

    // Count negedges until done, bounded; -1 on timeout
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sys_clk);
            if (done_v[0]) begin
                n = k;
                break;
            end
        end
        if (n < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic conv(input logic [15:0] v, input bit s);
        int n;
        @(negedge sys_clk);
        start = 1; bin_in = v; signed_en = s;
        @(negedge sys_clk);
        start = 0;
        wait_done(n);
        chk("latency", n + 1, BIN_W + 2);
    endtask

    initial begin
        int n;
        logic [15:0] v;
        repeat (2) @(negedge sys_clk);
        chk_on = 1;
        chk("rst_bcd0", bcd0, 20'h0);
        chk("rst_busy", busy_v, 3'b0);
        chk("rst_done", done_v, 3'b0);
        @(negedge sys_clk);
        reset_n = 1;
        repeat (3) @(negedge sys_clk);

        conv(16'd0, 0);      chk("zero", bcd0, 20'h00000); chk("zero_ovf", ovf_v[0], 0);
        conv(16'hFFFF, 0);   chk("ffff_u", bcd0, 20'h65535); chk("ffff_u_sign", sign_v[0], 0);
        conv(16'hFFFF, 1);   chk("ffff_s", bcd0, 20'h00001); chk("ffff_s_sign", sign_v[0], 1);
        conv(16'h8000, 1);   chk("min_s", bcd0, 20'h32768); chk("min_s_sign", sign_v[0], 1);
        conv(16'h7FFF, 1);   chk("max_s", bcd0, 20'h32767); chk("max_s_sign", sign_v[0], 0);
        conv(16'd12345, 0);
        chk("sat4", bcd1, 16'h9999);   chk("sat4_ovf", ovf_v[1], 1);
        chk("trunc4", bcd2, 16'h2345); chk("trunc4_ovf", ovf_v[2], 1);
        conv(16'd9999, 0);   chk("edge4", bcd1, 16'h9999); chk("edge4_ovf", ovf_v[1], 0);
        conv(16'd0, 1);      chk("zero_s_sign", sign_v[0], 0);

        // start pulsed mid-conversion is ignored
        @(negedge sys_clk); start = 1; bin_in = 16'd1234; signed_en = 0;
        @(negedge sys_clk); start = 0;
        repeat (4) @(negedge sys_clk);
        start = 1; bin_in = 16'd999;
        @(negedge sys_clk); start = 0;
        wait_done(n);
        chk("midstart_lat", n + 6, BIN_W + 2);
        chk("midstart_val", bcd0, 20'h01234);

        // start held through done: second conversion starts in the done cycle
        @(negedge sys_clk); start = 1; bin_in = 16'd100;
        wait_done(n);
        chk("hold1_lat", n, BIN_W + 2);
        chk("hold1_val", bcd0, 20'h00100);
        bin_in = 16'd200;
        @(negedge sys_clk); start = 0;
        wait_done(n);
        chk("hold2_lat", n + 1, BIN_W + 2);
        chk("hold2_val", bcd0, 20'h00200);

        // input changes during a conversion have no effect
        @(negedge sys_clk); start = 1; bin_in = 16'd4321; signed_en = 0;
        @(negedge sys_clk); start = 0;
        repeat (2) @(negedge sys_clk);
        bin_in = 16'hFFFF; signed_en = 1;
        wait_done(n);
        chk("chg_lat", n + 3, BIN_W + 2);
        chk("chg_val", bcd0, 20'h04321);
        chk("chg_sign", sign_v[0], 0);

        // reset mid-conversion aborts with no done
        @(negedge sys_clk); start = 1; bin_in = 16'd5555; signed_en = 0;
        @(negedge sys_clk); start = 0;
        repeat (6) @(negedge sys_clk);
        reset_n = 0;
        @(negedge sys_clk); reset_n = 1;
        chk("abort_bcd", bcd0, 20'h0);
        chk("abort_busy", busy_v, 3'b0);
        for (int k = 0; k < 25; k++) begin
            @(negedge sys_clk);
            chk("abort_nodone", done_v, 3'b0);
        end
        conv(16'd42, 0);     chk("after_abort", bcd0, 20'h00042);

        // randomized conversions with random idle gaps
        repeat (40) begin
            v = 16'($urandom);
            if ($urandom_range(0, 7) == 0) v = 16'h8000;
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            conv(v, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
